// File: rtl/rv_imm_pkg.sv
// Opcode map, format codes and the combinational immediate decoder shared by
// the decode-stage immediate expander.
package rv_imm_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef struct packed {
        logic        illegal;
        fmt_e        fmt;
        logic [63:0] imm;
    } dec_t;

    // Immediate is always built at 64 bits; callers keep the low XLEN bits.
    function automatic dec_t decode_imm(input logic [31:0] instr, input int unsigned xlen);
        dec_t        d;
        logic [63:0] sx;
        logic [63:0] imm_i;
        logic        rv64;
        logic        is_shift;
        sx       = {64{instr[31]}};
        imm_i    = {sx[63:12], instr[31:20]};
        rv64     = (xlen == 64);
        is_shift = (instr[13:12] == 2'b01);
        d.illegal = 1'b0;
        d.fmt     = FMT_R;
        d.imm     = '0;
        case (instr[6:0])
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                d.fmt = FMT_I;
                d.imm = imm_i;
            end
            OP_IMM: begin
                d.fmt = FMT_I;
                if (is_shift) begin
                    d.imm = rv64 ? {58'd0, instr[25:20]} : {59'd0, instr[24:20]};
                end else begin
                    d.imm = imm_i;
                end
            end
            OP_IMM32: begin
                if (rv64) begin
                    d.fmt = FMT_I;
                    d.imm = is_shift ? {59'd0, instr[24:20]} : imm_i;
                end else begin
                    d.illegal = 1'b1;
                end
            end
            OP_STORE: begin
                d.fmt = FMT_S;
                d.imm = {sx[63:12], instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                d.fmt = FMT_B;
                d.imm = {sx[63:13], instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                d.fmt = FMT_U;
                d.imm = {sx[63:32], instr[31:12], 12'd0};
            end
            OP_JAL: begin
                d.fmt = FMT_J;
                d.imm = {sx[63:21], instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_OP: d.fmt = FMT_R;
            OP_OP32: d.illegal = !rv64;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rv_skid_buf.sv
// Generic 2-entry valid/ready register slice: a main output register plus one
// skid entry, with registered in_ready and a synchronous flush.
module rv_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             ready_q;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_xfer;
    logic             main_free;

    assign in_xfer   = in_valid_i && ready_q;
    assign main_free = !main_valid_q || out_ready_i;

    // ready_q is low exactly while the skid holds data, so an accepted input
    // never collides with a skid drain.
    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = in_xfer;
                if (in_xfer) begin
                    main_d = in_data_i;
                end
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_d       = in_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= !skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_q;

endmodule

// File: rtl/rv_imm_expand.sv
// Decode-stage immediate expander: classify, sign-extend, optionally compute
// the PC-relative target, and register the result through a skid buffer.
module rv_imm_expand
    import rv_imm_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned TGT_EN = 1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic [XLEN-1:0] target_o,
    output logic            illegal_o
);

    localparam int unsigned PW = 1 + 3 + 2 * XLEN;

    dec_t            dec;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [PW-1:0]   payload_in;
    logic [PW-1:0]   payload_out;

    assign dec = decode_imm(instr_i, XLEN);
    assign imm = dec.imm[XLEN-1:0];

    generate
        if (TGT_EN != 0) begin : g_tgt
            logic use_tgt;
            assign use_tgt = !dec.illegal &&
                             (dec.fmt == FMT_B || dec.fmt == FMT_J || instr_i[6:0] == OP_AUIPC);
            assign target  = use_tgt ? pc_i + imm : '0;
        end else begin : g_no_tgt
            assign target = '0;
        end
    endgenerate

    assign payload_in = {dec.illegal, dec.fmt, imm, target};

    rv_skid_buf #(
        .WIDTH(PW)
    ) u_skid (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (payload_in),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (payload_out)
    );

    assign {illegal_o, fmt_o, imm_o, target_o} = payload_out;

endmodule

// File: tb/tb_rv_imm_expand.sv
// Self-checking bench: XLEN=64, XLEN=32 and target-less instances share stimulus;
// a scoreboard queue pairs accepted instructions with presented results.
module tb_rv_imm_expand;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [2:0]  f64;
        logic [63:0] i64;
        logic [63:0] t64;
        logic        l64;
        logic [2:0]  f32;
        logic [31:0] i32;
        logic [31:0] t32;
        logic        l32;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        out_ready;

    logic        a_ready, a_valid, a_ill;
    logic [63:0] a_imm, a_tgt;
    logic [2:0]  a_fmt;
    logic        b_ready, b_valid, b_ill;
    logic [31:0] b_imm, b_tgt;
    logic [2:0]  b_fmt;
    logic        c_ready, c_valid, c_ill;
    logic [63:0] c_imm, c_tgt;
    logic [2:0]  c_fmt;

    always #5 clk = ~clk;

    rv_imm_expand #(.XLEN(64), .TGT_EN(1)) u_dut64 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(a_ready), .instr_i(instr), .pc_i(pc), .out_valid_o(a_valid),
        .out_ready_i(out_ready), .imm_o(a_imm), .fmt_o(a_fmt), .target_o(a_tgt),
        .illegal_o(a_ill));

    rv_imm_expand #(.XLEN(32), .TGT_EN(1)) u_dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(b_ready), .instr_i(instr), .pc_i(pc[31:0]), .out_valid_o(b_valid),
        .out_ready_i(out_ready), .imm_o(b_imm), .fmt_o(b_fmt), .target_o(b_tgt),
        .illegal_o(b_ill));

    rv_imm_expand #(.XLEN(64), .TGT_EN(0)) u_dut_nt (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(c_ready), .instr_i(instr), .pc_i(pc), .out_valid_o(c_valid),
        .out_ready_i(out_ready), .imm_o(c_imm), .fmt_o(c_fmt), .target_o(c_tgt),
        .illegal_o(c_ill));

    int   tests_run = 0;
    int   failed    = 0;
    int   n_out     = 0;
    vec_t tbl[17];
    vec_t cur;
    vec_t q[$];
    logic stall_prev = 1'b0;
    logic saw_not_ready = 1'b0;
    logic [63:0] held_imm, held_tgt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] ins, input logic [63:0] p,
                                input logic [2:0] f64, input logic [63:0] i64,
                                input logic [63:0] t64, input logic l64,
                                input logic [2:0] f32, input logic [31:0] i32,
                                input logic [31:0] t32, input logic l32);
        vec_t v;
        v.instr = ins; v.pc = p;
        v.f64 = f64; v.i64 = i64; v.t64 = t64; v.l64 = l64;
        v.f32 = f32; v.i32 = i32; v.t32 = t32; v.l32 = l32;
        return v;
    endfunction

    // Scoreboard / monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stable_valid", {63'd0, a_valid}, 64'd1);
                chk("stable_imm", a_imm, held_imm);
                chk("stable_tgt", a_tgt, held_tgt);
            end
            if (flush) begin
                q.delete();
                stall_prev = 1'b0;
            end else begin
                if (a_valid && out_ready) begin
                    if (q.size() == 0) begin
                        tests_run++;
                        failed++;
                        $display("[TB] FAIL sb_underflow: got result imm=0x%0h, expected none", a_imm);
                    end else begin
                        vec_t e;
                        e = q.pop_front();
                        n_out++;
                        $display("[TB] out %0d instr=%08h imm64=%016h fmt=%0d tgt64=%0h ill=%0b",
                                 n_out, e.instr, a_imm, a_fmt, a_tgt, a_ill);
                        chk("imm64", a_imm, e.i64);
                        chk("fmt64", {61'd0, a_fmt}, {61'd0, e.f64});
                        chk("tgt64", a_tgt, e.t64);
                        chk("ill64", {63'd0, a_ill}, {63'd0, e.l64});
                        chk("imm32", {32'd0, b_imm}, {32'd0, e.i32});
                        chk("fmt32", {61'd0, b_fmt}, {61'd0, e.f32});
                        chk("tgt32", {32'd0, b_tgt}, {32'd0, e.t32});
                        chk("ill32", {63'd0, b_ill}, {63'd0, e.l32});
                        chk("imm_nt", c_imm, e.i64);
                        chk("tgt_nt", c_tgt, 64'd0);
                    end
                end
                if (in_valid && a_ready) q.push_back(cur);
                if (in_valid && !a_ready) saw_not_ready = 1'b1;
                stall_prev = a_valid && !out_ready;
                held_imm   = a_imm;
                held_tgt   = a_tgt;
            end
        end
    end

    task automatic drive(input int i);
        cur      = tbl[i];
        instr    = tbl[i].instr;
        pc       = tbl[i].pc;
        in_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 50 && q.size() != 0; c++) step();
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, {63'd0, a_valid}, 64'd0);
        chk({tag, "_ready"}, {63'd0, a_ready}, 64'd1);
        chk({tag, "_imm"}, a_imm, 64'd0);
        chk({tag, "_fmt"}, {61'd0, a_fmt}, 64'd0);
        chk({tag, "_tgt"}, a_tgt, 64'd0);
        chk({tag, "_ill"}, {63'd0, a_ill}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; out_ready = 1'b1;
        tbl[0]  = mk(32'hFFF00093, 64'h0,    3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,    1'b0, 3'd1, 32'hFFFF_FFFF, 32'h0, 1'b0);
        tbl[1]  = mk(32'hFE000EE3, 64'h1000, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFC,  1'b0, 3'd3, 32'hFFFF_FFFC, 32'hFFC, 1'b0);
        tbl[2]  = mk(32'hFFF0809B, 64'h0,    3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,    1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        tbl[3]  = mk(32'h03F09093, 64'h0,    3'd1, 64'h3F,                  64'h0,    1'b0, 3'd1, 32'h1F, 32'h0, 1'b0);
        tbl[4]  = mk(32'h4010D093, 64'h0,    3'd1, 64'h1,                   64'h0,    1'b0, 3'd1, 32'h1, 32'h0, 1'b0);
        tbl[5]  = mk(32'h41F0D09B, 64'h0,    3'd1, 64'h1F,                  64'h0,    1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        tbl[6]  = mk(32'hFE20AC23, 64'h0,    3'd2, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,    1'b0, 3'd2, 32'hFFFF_FFF8, 32'h0, 1'b0);
        tbl[7]  = mk(32'h800000B7, 64'h0,    3'd4, 64'hFFFF_FFFF_8000_0000, 64'h0,    1'b0, 3'd4, 32'h8000_0000, 32'h0, 1'b0);
        tbl[8]  = mk(32'h12345097, 64'h1000, 3'd4, 64'h1234_5000, 64'h1234_6000,      1'b0, 3'd4, 32'h1234_5000, 32'h1234_6000, 1'b0);
        tbl[9]  = mk(32'h0010006F, 64'h2000, 3'd5, 64'h800,                 64'h2800, 1'b0, 3'd5, 32'h800, 32'h2800, 1'b0);
        tbl[10] = mk(32'hFFFFF06F, 64'h100,  3'd5, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFE,   1'b0, 3'd5, 32'hFFFF_FFFE, 32'hFE, 1'b0);
        tbl[11] = mk(32'h003100B3, 64'h0,    3'd0, 64'h0,                   64'h0,    1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        tbl[12] = mk(32'h003100BB, 64'h0,    3'd0, 64'h0,                   64'h0,    1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        tbl[13] = mk(32'hFFFFFFFF, 64'h1234, 3'd0, 64'h0,                   64'h0,    1'b1, 3'd0, 32'h0, 32'h0, 1'b1);
        tbl[14] = mk(32'h004100E7, 64'h40,   3'd1, 64'h4,                   64'h0,    1'b0, 3'd1, 32'h4, 32'h0, 1'b0);
        tbl[15] = mk(32'h02000063, 64'hFFFF_FFFF_FFFF_FFF0, 3'd3, 64'h20,   64'h10,   1'b0, 3'd3, 32'h20, 32'h10, 1'b0);
        tbl[16] = mk(32'h80001073, 64'h0,    3'd1, 64'hFFFF_FFFF_FFFF_F800, 64'h0,    1'b0, 3'd1, 32'hFFFF_F800, 32'h0, 1'b0);

        repeat (3) step();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        step();

        // First-instruction latency.
        drive(0);
        step();
        in_valid = 1'b0;
        chk("lat_valid", {63'd0, a_valid}, 64'd1);
        step();

        // Full vector table back-to-back.
        for (int i = 0; i < 17; i++) begin
            drive(i);
            step();
        end
        in_valid = 1'b0;
        wait_drain();

        // 8-instruction stream with downstream stall.
        saw_not_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic acc;
                    int   guard;
                    drive(i);
                    guard = 0;
                    do begin
                        @(negedge clk);
                        acc = a_ready;
                        step();
                        guard++;
                    end while (!acc && guard < 20);
                    if (!acc) chk("accept_timeout", {63'd0, acc}, 64'd1);
                end
                in_valid = 1'b0;
            end
            begin
                out_ready = 1'b1;
                repeat (2) step();
                out_ready = 1'b0;
                repeat (3) step();
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("ready_low_seen", {63'd0, saw_not_ready}, 64'd1);
        chk("ready_back", {63'd0, a_ready}, 64'd1);

        // Flush with both entries full and an input offered.
        out_ready = 1'b0;
        drive(9);  step();
        drive(10); step();
        chk("skid_full_ready", {63'd0, a_ready}, 64'd0);
        drive(11);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {63'd0, a_valid}, 64'd0);
        chk("flush_ready", {63'd0, a_ready}, 64'd1);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            chk("flush_no_out", {63'd0, a_valid}, 64'd0);
        end

        // Flush with only the main entry full, so the offered input would transfer.
        out_ready = 1'b0;
        drive(14); step();
        drive(15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("flush2_valid", {63'd0, a_valid}, 64'd0);
        step();
        chk("flush2_no_out", {63'd0, a_valid}, 64'd0);

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        drive(1); step();
        drive(6); step();
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        drive(8);
        step();
        in_valid = 1'b0;
        chk("lat2_valid", {63'd0, a_valid}, 64'd1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/rv_imm_expand.md
# rv_imm_expand

Pipelined, parametrised immediate expander for the decode stage. Each accepted 32-bit instruction is classified by opcode into R/I/S/B/U/J format. The block sign-extends its immediate to XLEN and computes the PC-relative target for branch, jump and auipc. Results are delivered through a registered valid/ready interface with a 2-entry skid buffer, so the block sits between fetch and the register-read stage at full throughput.

## Interface
Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- TGT_EN, 1, 1 = compute target_o; 0 = target_o tied to 0 and the adder is removed.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous pipeline flush
- in_valid_i  in  1  instruction valid
- in_ready_o  out  1  block can accept
- instr_i  in  32  instruction word
- pc_i  in  XLEN  instruction address
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts
- imm_o  out  XLEN  expanded immediate
- fmt_o  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5
- target_o  out  XLEN  pc_i + imm for B/J/auipc; 0 otherwise
- illegal_o  out  1  opcode not supported at this XLEN

## Operation
- Transfer rules:
  - Input transfer when in_valid_i && in_ready_o.
  - Output transfer when out_valid_o && out_ready_i.
- Format by instr_i[6:0]:
  - I: 0000011, 0010011, 0011011 (XLEN=64 only), 1100111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011, 0111011 (XLEN=64 only); imm = 0.
- Immediate encodings (all sign-extended from bit 31 to XLEN):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Shifts: opcode 0010011 with funct3 001/101 gives zero-extended shamt.
  - XLEN=64: instr[25:20].
  - XLEN=32, or opcode 0011011: instr[24:20].
- target_o: only for B, J, and U with opcode 0010111 (auipc); pc_i + imm modulo 2^XLEN, wrap-around ignored.
- Illegal handling:
  - Covers an unknown opcode, or any opcode marked 64-only when XLEN=32.
  - Sets illegal_o=1, fmt_o=0, imm_o=0, target_o=0.
  - The entry still flows through the pipeline like a legal one.

## Timing
- Reset values: in_ready_o=1, out_valid_o=0, imm_o=0, fmt_o=0, target_o=0, illegal_o=0; both skid entries empty.
- Latency: an instruction accepted in cycle N is presented in cycle N+1 if the output register is empty or draining.
- Throughput: one instruction per cycle while out_ready_i=1.
- Skid buffer: the main register holds the presented result. When the main register is held (out_ready_i=0) and an input transfers, the new result goes to the skid register.
- in_ready_o is a register: it is 0 exactly while the skid entry is occupied, and returns to 1 the cycle after the skid drains into the main register.
- All outputs come straight from flops; there is no combinational path from instr_i to any output, or from out_ready_i to in_ready_o.
- Output stability: while out_valid_o=1 and out_ready_i=0, all output fields stay stable.
- flush_i:
  - Takes priority over everything else.
  - Next cycle out_valid_o=0, skid empty, in_ready_o=1.
  - An input offered in the flush cycle is discarded.
- Simultaneous input and output transfers with the skid empty: the main register reloads and the skid stays empty.
- Reset mid-operation: all entries are dropped immediately; the values are as listed under reset values.

## Structure
- Package rv_imm_pkg holds:
  - opcode localparams;
  - fmt encoding constants;
  - a combinational function producing {illegal, fmt, imm} from instr and XLEN.
- Sub-module rv_skid_buf(WIDTH): generic 2-entry valid/ready skid register, reused later by the fetch and execute stages.
- The top level holds the decode function, the TGT_EN-gated adder, and the packing of fields into the skid payload.

## Test plan
- XLEN=64; I-type 0xFFF00093 (addi x1,x0,-1) -> imm_o=0xFFFF_FFFF_FFFF_FFFF, fmt_o=1, one cycle after accept.
- XLEN=64; branch 0xFE000EE3 (beq x0,x0,-4), pc_i=0x1000 -> imm_o=-4, fmt_o=3, target_o=0xFFC.
- XLEN=32; opcode 0x1B (addiw) -> illegal_o=1, imm_o=0, fmt_o=0; same word at XLEN=64 -> fmt_o=1, no illegal.
- Back-to-back 8 instructions with out_ready_i low for cycles 3-5 -> in_ready_o low 1 cycle after the skid fills; all 8 results emerge in order, none lost or duplicated; outputs stable while stalled.
- flush_i asserted with both entries full and in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1; the flushed-cycle input never appears.
- rst_n_i asserted mid-stream -> outputs take reset values asynchronously; the first instruction after release has 1-cycle latency.
